// File: rtl/div_sequencer.sv
// div_sequencer: radix-2 restoring divide/remainder sequencer for EX with pipeline stall; define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow in the issue cycle.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_en_e,
  input  logic [1:0]       div_ctrl_e,
  input  logic [WIDTH-1:0] op_a_e,
  input  logic [WIDTH-1:0] op_b_e,
  input  logic             cache_stall,
  output logic             div_stall,
  output logic [WIDTH-1:0] div_result,
  output logic             div_done,
  output logic             div_busy
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] op;
  logic sign_a, sign_b, b_zero, sa_e, sb_e, early;
  logic [WIDTH-1:0] orig_a, abs_b, rem, quo, result, abs_a_e, abs_b_e, q_fix, r_fix, fix_res, early_res;
  logic [WIDTH:0] rem_sh, diff;
  assign sa_e = ~div_ctrl_e[0] & op_a_e[WIDTH-1];
  assign sb_e = ~div_ctrl_e[0] & op_b_e[WIDTH-1];
  assign abs_a_e = sa_e ? -op_a_e : op_a_e;
  assign abs_b_e = sb_e ? -op_b_e : op_b_e;
  // Remainder and quotient shift together; the quotient register starts as |a|.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff = rem_sh - {1'b0, abs_b};
  assign q_fix = (sign_a ^ sign_b) ? -quo : quo;
  assign r_fix = sign_a ? -rem : rem;
  assign fix_res = op[1] ? (b_zero ? orig_a : r_fix) : (b_zero ? '1 : q_fix);
`ifdef DIV_EARLY_OUT_EN
  assign early = (op_b_e == '0) | (~div_ctrl_e[0] & (op_a_e == {1'b1, {(WIDTH-1){1'b0}}}) & (&op_b_e));
  assign early_res = (op_b_e == '0) ? (div_ctrl_e[1] ? op_a_e : '1) : (div_ctrl_e[1] ? '0 : op_a_e);
`else
  assign early = 1'b0;
  assign early_res = '0;
`endif
  assign div_stall = ((state == IDLE) & div_en_e) | (state == RUN) | (state == FIX);
  assign div_done = state == DONE;
  assign div_busy = state != IDLE;
  assign div_result = div_done ? result : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (div_en_e) begin
          op <= div_ctrl_e;
          sign_a <= sa_e;
          sign_b <= sb_e;
          b_zero <= op_b_e == '0;
          orig_a <= op_a_e;
          abs_b <= abs_b_e;
          quo <= abs_a_e;
          rem <= '0;
          cnt <= '0;
          if (early) result <= early_res;
          state <= early ? DONE : RUN;
        end
        RUN: begin
          rem <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          result <= fix_res;
          state <= DONE;
        end
        default: if (!cache_stall) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: table vectors, hand sequences and random divides against an arithmetic reference model.
module tb_div_sequencer;
  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int SP_STALL = 1;
`else
  localparam int SP_STALL = W + 2;
`endif
  logic clk = 0, rst = 1, div_en_e = 0, cache_stall = 0;
  logic [1:0] div_ctrl_e = 0;
  logic [W-1:0] op_a_e = 0, op_b_e = 0;
  logic div_stall, div_done, div_busy;
  logic [W-1:0] div_result;
  int n_cmp = 0, n_err = 0;
  div_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .div_en_e(div_en_e), .div_ctrl_e(div_ctrl_e),
    .op_a_e(op_a_e), .op_b_e(op_b_e), .cache_stall(cache_stall),
    .div_stall(div_stall), .div_result(div_result), .div_done(div_done), .div_busy(div_busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] c;
    logic [W-1:0] a, b, exp;
    logic sp;
  } vec_t;
  vec_t tbl[13];
  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [W-1:0] ref_div(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return c[1] ? a : '1;
    if (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return c[1] ? '0 : a;
    case (c)
      2'd0: return $signed(a) / $signed(b);
      2'd1: return a / b;
      2'd2: return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction
  function automatic int ref_stall(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0 || (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? SP_STALL : W + 2;
  endfunction
  // Entered and left at negedge+1; leaves the DUT back in IDLE with div_en_e low.
  task automatic do_div(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input int cs,
                        output logic [W-1:0] res, output int stalls, output int holds, output logic stable);
    div_en_e = 1; div_ctrl_e = c; op_a_e = a; op_b_e = b;
    #1;
    stalls = 0;
    while (div_stall && stalls < 100) begin
      stalls++;
      @(negedge clk); #1;
    end
    res = div_result;
    holds = 0;
    stable = 1;
    while (div_done && holds < 100) begin
      if (div_result !== res) stable = 0;
      cache_stall = holds < cs;
      holds++;
      @(negedge clk); #1;
    end
    cache_stall = 0;
    div_en_e = 0;
  endtask
  initial begin
    logic [W-1:0] res, a, b;
    logic [1:0] c;
    int st, h, sel;
    logic stb;
    tbl[0]  = '{2'd0, 32'd100,        32'd7,          32'd14,         1'b0};
    tbl[1]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
    tbl[2]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
    tbl[3]  = '{2'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0};
    tbl[4]  = '{2'd3, 32'h8000_0000,  32'h8000_0001,  32'h8000_0000,  1'b0};
    tbl[5]  = '{2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
    tbl[6]  = '{2'd2, 32'd5,          32'd0,          32'd5,          1'b1};
    tbl[7]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
    tbl[8]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
    tbl[9]  = '{2'd1, 32'd7,          32'd0,          32'hFFFF_FFFF,  1'b1};
    tbl[10] = '{2'd3, 32'h1234_5678,  32'd0,          32'h1234_5678,  1'b1};
    tbl[11] = '{2'd0, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0};
    tbl[12] = '{2'd2, 32'd100,        32'hFFFF_FFF9,  32'd2,          1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_busy", 32'(div_busy), 0);
    check("reset_done", 32'(div_done), 0);
    check("reset_result", div_result, 0);
    check("reset_stall", 32'(div_stall), 0);
    div_en_e = 1; #1;
    check("reset_stall_en", 32'(div_stall), 1);
    div_en_e = 0;
    rst = 0;
    @(negedge clk); #1;
    foreach (tbl[i]) begin
      do_div(tbl[i].c, tbl[i].a, tbl[i].b, 0, res, st, h, stb);
      check($sformatf("tbl%0d_result", i), res, tbl[i].exp);
      check($sformatf("tbl%0d_stall", i), st, tbl[i].sp ? SP_STALL : W + 2);
      check($sformatf("tbl%0d_done_cycles", i), h, 1);
    end
    do_div(2'd0, 32'd1000, 32'd10, 3, res, st, h, stb);
    check("cache_result", res, 32'd100);
    check("cache_hold_cycles", h, 4);
    check("cache_stable", 32'(stb), 1);
    check("cache_idle_busy", 32'(div_busy), 0);
    @(negedge clk); #1;
    check("cache_no_reissue", 32'(div_busy), 0);
    div_en_e = 1; div_ctrl_e = 2'd0; op_a_e = 32'd100; op_b_e = 32'd7;
    repeat (11) @(negedge clk);
    #1;
    check("mid_run_busy", 32'(div_busy), 1);
    rst = 1; div_en_e = 0;
    @(negedge clk); #1;
    check("rst_run_busy", 32'(div_busy), 0);
    check("rst_run_result", div_result, 0);
    check("rst_run_done", 32'(div_done), 0);
    check("rst_run_stall", 32'(div_stall), 0);
    rst = 0;
    do_div(2'd0, 32'd9, 32'd3, 0, res, st, h, stb);
    check("after_rst_result", res, 32'd3);
    check("after_rst_stall", st, W + 2);
    for (int i = 0; i < 40; i++) begin
      c = 2'($urandom_range(0, 3));
      a = $urandom;
      sel = $urandom_range(0, 7);
      b = sel == 0 ? 32'd0 : sel == 1 ? 32'hFFFF_FFFF : sel == 2 ? 32'($urandom_range(1, 15)) : $urandom;
      if (sel == 1 && $urandom_range(0, 1) == 1) a = 32'h8000_0000;
      do_div(c, a, b, $urandom_range(0, 2), res, st, h, stb);
      check($sformatf("rnd%0d_result c=%0d a=%h b=%h", i, c, a, b), res, ref_div(c, a, b));
      check($sformatf("rnd%0d_stall", i), st, ref_stall(c, a, b));
      check($sformatf("rnd%0d_stable", i), 32'(stb), 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
